// File: rtl/ram_pkg.sv
// ram_pkg: shared types, constants and helpers for the ram_sdp_be data RAM.
//   ram_state_t  : zero-fill engine states (ST_CLEAR, ST_READY)
//   RDW_OLD      : read-during-write returns the stored (pre-write) word
//   RDW_NEW_DATA : read-during-write returns the byte-merged new word
//   be_merge     : per-byte select between stored and incoming data
package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    localparam int RDW_OLD      = 0;
    localparam int RDW_NEW_DATA = 1;

    // One byte lane of a byte-enable merge. The write path and the forwarding
    // path both build their words from this, so they can never disagree.
    function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
        logic [7:0] res;
        if (be) begin
            res = new_b;
        end else begin
            res = old_b;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: request/response bundle of the simple-dual-port data RAM.
//   clear_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr : requester -> RAM
//   busy, rd_data, rd_valid, oob_err                          : RAM -> requester
interface ram_sdp_be_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  clear_req;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  oob_err;

    modport master (
        output clear_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, oob_err
    );

    modport slave (
        input  clear_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid, oob_err
    );
endinterface

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: RD_LAT-deep delay line for read data and its valid flag.
//   clock, reset_n : clock and asynchronous active-low clear
//   in_valid/in_data   : word produced by the array in the accepting cycle
//   out_valid/out_data : same word RD_LAT edges later
// A stage only loads data when the stage before it is valid, so the output
// word holds its last value while out_valid is low.
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0]             valid_r;
    logic [RD_LAT-1:0][DATA_W-1:0] data_r;

    // Shift valid and data through all stages; reset flushes reads in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
            data_r  <= '0;
        end else begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= in_data;
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                valid_r[i] <= valid_r[i-1];
                if (valid_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    assign out_valid = valid_r[RD_LAT-1];
    assign out_data  = data_r[RD_LAT-1];

endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with byte-enable writes, RD_LAT-cycle reads,
// selectable read-during-write result and a zero-fill engine.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset; starts a zero-fill
//   bus     : slave side of ram_sdp_be_if (clear_req/busy, write port,
//             read port with rd_valid, oob_err pulse)
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 32,
    parameter int RD_LAT  = 1,
    parameter int RDW_NEW = 0
) (
    input  logic         clock,
    input  logic         reset_n,
    ram_sdp_be_if.slave  bus
);

    localparam int                BE_W      = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state_r, state_nxt_s;
    logic [ADDR_W-1:0] cnt_r, cnt_nxt_s;
    logic              busy_r;
    logic              oob_r, oob_nxt_s;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              ready_s;
    logic              wr_in_range_s, rd_in_range_s;
    logic              wr_acc_s, rd_acc_s;
    logic [DATA_W-1:0] wr_old_s, wr_merged_s, rd_word_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    assign ready_s       = (state_r == ST_READY);
    assign wr_in_range_s = ({1'b0, bus.wr_addr} < DEPTH_X);
    assign rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_X);
    assign wr_acc_s      = ready_s & bus.wr_en;
    assign rd_acc_s      = ready_s & bus.rd_en;
    assign oob_nxt_s     = (wr_acc_s & ~wr_in_range_s) | (rd_acc_s & ~rd_in_range_s);

    // Merged write word; also the forwarded word for a same-address read.
    assign wr_old_s = mem_r[bus.wr_addr];
    for (genvar g = 0; g < BE_W; g++) begin : g_merge
        assign wr_merged_s[8*g +: 8] = be_merge(wr_old_s[8*g +: 8],
                                                bus.wr_data[8*g +: 8],
                                                bus.wr_be[g]);
    end

    // Next-state logic: walk cnt through the array, or start a fill on request.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_READY;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear_req) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Array write port select: zero-fill owns the port while clearing.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.wr_addr;
        mem_wdata_s = wr_merged_s;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_r;
                mem_wdata_s = '0;
            end
            ST_READY: begin
                mem_we_s    = wr_acc_s & wr_in_range_s;
            end
            default: begin
                mem_we_s    = 1'b0;
            end
        endcase
    end

    // Read word for the accepting cycle, including same-address forwarding.
    always_comb begin
        rd_word_s = '0;
        if (!rd_in_range_s) begin
            rd_word_s = '0;
        end else if ((RDW_NEW == RDW_NEW_DATA) && wr_acc_s && wr_in_range_s &&
                     (bus.wr_addr == bus.rd_addr)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem_r[bus.rd_addr];
        end
    end

    // Control registers: FSM state, fill counter, busy and oob_err.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            oob_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_CLEAR);
            oob_r   <= oob_nxt_s;
        end
    end

    // Storage array; contents are made known by the zero-fill, not by reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_acc_s),
        .in_data   (rd_word_s),
        .out_valid (bus.rd_valid),
        .out_data  (bus.rd_data)
    );

    assign bus.busy    = busy_r;
    assign bus.oob_err = oob_r;

endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be: directed bench for ram_sdp_be. Three instances share one
// stimulus: dut_a (DEPTH 32, RD_LAT 1, old data on RDW), dut_b (DEPTH 32,
// RD_LAT 2, new data on RDW) and dut_c (DEPTH 24, RD_LAT 1, old data on RDW).
module tb_ram_sdp_be;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        clear_req = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  wr_be = 4'd0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = 5'd0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram_sdp_be_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
    ram_sdp_be_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
    ram_sdp_be_if #(.DATA_W(32), .ADDR_W(5)) bus_c ();

    assign bus_a.clear_req = clear_req; assign bus_a.wr_en = wr_en; assign bus_a.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data; assign bus_a.wr_be = wr_be; assign bus_a.rd_en = rd_en;
    assign bus_a.rd_addr = rd_addr;
    assign bus_b.clear_req = clear_req; assign bus_b.wr_en = wr_en; assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data; assign bus_b.wr_be = wr_be; assign bus_b.rd_en = rd_en;
    assign bus_b.rd_addr = rd_addr;
    assign bus_c.clear_req = clear_req; assign bus_c.wr_en = wr_en; assign bus_c.wr_addr = wr_addr;
    assign bus_c.wr_data = wr_data; assign bus_c.wr_be = wr_be; assign bus_c.rd_en = rd_en;
    assign bus_c.rd_addr = rd_addr;

    ram_sdp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .RDW_NEW(0))
        dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
    ram_sdp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .RD_LAT(2), .RDW_NEW(1))
        dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));
    ram_sdp_be #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .RD_LAT(1), .RDW_NEW(0))
        dut_c (.clock(clock), .reset_n(reset_n), .bus(bus_c));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        clear_req = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    // Single read; returns {valid,data} of each instance at its own latency,
    // and flags a valid seen at the wrong latency.
    task automatic read_capture(input logic [4:0] a, output logic [32:0] ra,
                                output logic [32:0] rb, output logic [32:0] rc,
                                output logic lat_bad);
        rd_en = 1'b1; rd_addr = a;
        step();
        rd_en = 1'b0;
        ra = {bus_a.rd_valid, bus_a.rd_data};
        rc = {bus_c.rd_valid, bus_c.rd_data};
        lat_bad = bus_b.rd_valid;
        step();
        rb = {bus_b.rd_valid, bus_b.rd_data};
        lat_bad = lat_bad | bus_a.rd_valid | bus_c.rd_valid;
    endtask

    // Counts edges until every instance drops busy; optionally watches rd_valid.
    task automatic count_busy(input int start, output int na, output int nb,
                              output int nc, output logic seen_valid);
        int n;
        n = start; na = -1; nb = -1; nc = -1; seen_valid = 1'b0;
        while ((na < 0 || nb < 0 || nc < 0) && n < 100) begin
            step();
            n++;
            if (n == 20) rd_en = 1'b0;
            seen_valid = seen_valid | bus_a.rd_valid | bus_b.rd_valid | bus_c.rd_valid;
            if (na < 0 && !bus_a.busy) na = n;
            if (nb < 0 && !bus_b.busy) nb = n;
            if (nc < 0 && !bus_c.busy) nc = n;
        end
    endtask

    task automatic test_reset();
        int na, nb, nc;
        logic seen;
        idle();
        #2 reset_n = 1'b0;
        step(); step();
        checks++;
        if ({bus_a.busy, bus_a.rd_valid, bus_a.oob_err, bus_a.rd_data} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL reset_a: got %b/%h expected 100/0", {bus_a.busy, bus_a.rd_valid, bus_a.oob_err}, bus_a.rd_data);
        end
        checks++;
        if ({bus_b.busy, bus_b.rd_valid, bus_b.oob_err, bus_b.rd_data} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL reset_b: got %b/%h expected 100/0", {bus_b.busy, bus_b.rd_valid, bus_b.oob_err}, bus_b.rd_data);
        end
        checks++;
        if ({bus_c.busy, bus_c.rd_valid, bus_c.oob_err, bus_c.rd_data} !== {3'b100, 32'h0}) begin
            errors++; $display("FAIL reset_c: got %b/%h expected 100/0", {bus_c.busy, bus_c.rd_valid, bus_c.oob_err}, bus_c.rd_data);
        end
        // Release and try to read during the fill; those reads must be ignored.
        reset_n = 1'b1; rd_en = 1'b1; rd_addr = 5'd5;
        count_busy(0, na, nb, nc, seen);
        idle();
        checks++;
        if (na !== 32 || nb !== 32 || nc !== 24) begin
            errors++; $display("FAIL fill_len: got %0d/%0d/%0d expected 32/32/24", na, nb, nc);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL clear_ignores_rd: got rd_valid %b expected 0", seen);
        end
    endtask

    task automatic test_read_zero();
        logic [32:0] ra, rb, rc; logic lb;
        read_capture(5'd5, ra, rb, rc, lb);
        checks++;
        if ({ra, rb, rc, lb} !== {1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0}) begin
            errors++; $display("FAIL read_zero: got %h %h %h lat %b expected 1_00000000 x3 lat 0", ra, rb, rc, lb);
        end
    endtask

    task automatic test_write_read();
        logic [32:0] ra, rb, rc; logic lb;
        write_word(5'd0, 32'd369, 4'hF);
        read_capture(5'd0, ra, rb, rc, lb);
        checks++;
        if ({ra, rb, rc, lb} !== {1'b1, 32'd369, 1'b1, 32'd369, 1'b1, 32'd369, 1'b0}) begin
            errors++; $display("FAIL write_read: got %h %h %h lat %b expected 1_00000171 x3 lat 0", ra, rb, rc, lb);
        end
    endtask

    task automatic test_byte_enable();
        logic [32:0] ra, rb, rc; logic lb;
        write_word(5'd1, 32'hAABBCCDD, 4'hF);
        write_word(5'd1, 32'h11223344, 4'b0101);
        read_capture(5'd1, ra, rb, rc, lb);
        checks++;
        if ({ra, rb, rc} !== {1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44}) begin
            errors++; $display("FAIL byte_enable: got %h %h %h expected 1_AA22CC44 x3", ra, rb, rc);
        end
        write_word(5'd1, 32'hFFFFFFFF, 4'h0);
        read_capture(5'd1, ra, rb, rc, lb);
        checks++;
        if ({ra, rb, rc} !== {1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1, 32'hAA22CC44}) begin
            errors++; $display("FAIL be_zero_noop: got %h %h %h expected 1_AA22CC44 x3", ra, rb, rc);
        end
    endtask

    task automatic test_rdw();
        logic [32:0] ra, rb, rc; logic lb;
        write_word(5'd2, 32'd123, 4'hF);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd999; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 5'd2;
        step();
        idle();
        ra = {bus_a.rd_valid, bus_a.rd_data};
        rc = {bus_c.rd_valid, bus_c.rd_data};
        step();
        rb = {bus_b.rd_valid, bus_b.rd_data};
        checks++;
        if ({ra, rc} !== {1'b1, 32'd123, 1'b1, 32'd123}) begin
            errors++; $display("FAIL rdw_old: got %h %h expected 1_0000007b x2", ra, rc);
        end
        checks++;
        if (rb !== {1'b1, 32'd999}) begin
            errors++; $display("FAIL rdw_new: got %h expected 1_000003e7", rb);
        end
        read_capture(5'd2, ra, rb, rc, lb);
        checks++;
        if ({ra, rb, rc} !== {1'b1, 32'd999, 1'b1, 32'd999, 1'b1, 32'd999}) begin
            errors++; $display("FAIL rdw_after: got %h %h %h expected 1_000003e7 x3", ra, rb, rc);
        end
    endtask

    task automatic test_oob();
        logic [32:0] ra, rb, rc; logic lb;
        write_word(5'd30, 32'd7, 4'hF);
        checks++;
        if ({bus_a.oob_err, bus_b.oob_err, bus_c.oob_err} !== 3'b001) begin
            errors++; $display("FAIL oob_wr_pulse: got %b expected 001", {bus_a.oob_err, bus_b.oob_err, bus_c.oob_err});
        end
        step();
        checks++;
        if (bus_c.oob_err !== 1'b0) begin
            errors++; $display("FAIL oob_wr_width: got %b expected 0", bus_c.oob_err);
        end
        read_capture(5'd6, ra, rb, rc, lb);
        checks++;
        if (rc !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL oob_no_alias: got %h expected 1_00000000", rc);
        end
        rd_en = 1'b1; rd_addr = 5'd30;
        step();
        rd_en = 1'b0;
        checks++;
        if ({bus_c.rd_valid, bus_c.rd_data, bus_c.oob_err} !== {1'b1, 32'h0, 1'b1}) begin
            errors++; $display("FAIL oob_rd: got %b/%h/%b expected 1/0/1", bus_c.rd_valid, bus_c.rd_data, bus_c.oob_err);
        end
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_a.oob_err} !== {1'b1, 32'd7, 1'b0}) begin
            errors++; $display("FAIL inrange_30: got %b/%h/%b expected 1/7/0", bus_a.rd_valid, bus_a.rd_data, bus_a.oob_err);
        end
        step();
        // Out-of-range read and write together: one single-cycle pulse.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'd5; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 5'd30;
        step();
        idle();
        lb = bus_c.oob_err;
        step();
        checks++;
        if ({lb, bus_c.oob_err} !== 2'b10) begin
            errors++; $display("FAIL oob_dual: got %b%b expected 10", lb, bus_c.oob_err);
        end
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1; rd_addr = 5'd0;
        step();
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data} !== {1'b1, 32'd369}) begin
            errors++; $display("FAIL b2b_a0: got %h expected 1_00000171", {bus_a.rd_valid, bus_a.rd_data});
        end
        rd_addr = 5'd1;
        step();
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_data} !== {1'b1, 32'hAA22CC44, 1'b1, 32'd369}) begin
            errors++; $display("FAIL b2b_1: got %h %h expected 1_AA22CC44 1_00000171", {bus_a.rd_valid, bus_a.rd_data}, {bus_b.rd_valid, bus_b.rd_data});
        end
        rd_addr = 5'd2;
        step();
        rd_en = 1'b0;
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_data} !== {1'b1, 32'd999, 1'b1, 32'hAA22CC44}) begin
            errors++; $display("FAIL b2b_2: got %h %h expected 1_000003e7 1_AA22CC44", {bus_a.rd_valid, bus_a.rd_data}, {bus_b.rd_valid, bus_b.rd_data});
        end
        step();
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_b.rd_valid, bus_b.rd_data} !== {1'b0, 32'd999, 1'b1, 32'd999}) begin
            errors++; $display("FAIL b2b_3: got %h %h expected 0_000003e7 1_000003e7", {bus_a.rd_valid, bus_a.rd_data}, {bus_b.rd_valid, bus_b.rd_data});
        end
        step();
        checks++;
        if ({bus_b.rd_valid, bus_b.rd_data} !== {1'b0, 32'd999}) begin
            errors++; $display("FAIL b2b_hold: got %h expected 0_000003e7", {bus_b.rd_valid, bus_b.rd_data});
        end
    endtask

    task automatic test_clear_inflight();
        logic [32:0] ra, rb, rc; logic lb, seen;
        int na, nb, nc;
        for (int i = 0; i < 4; i++) write_word(5'(i), 32'd123, 4'hF);
        // Read and clear request in the same cycle: the read still completes.
        rd_en = 1'b1; rd_addr = 5'd0; clear_req = 1'b1;
        step();
        idle();
        checks++;
        if ({bus_a.rd_valid, bus_a.rd_data, bus_a.busy, bus_b.busy, bus_c.busy} !== {1'b1, 32'd123, 3'b111}) begin
            errors++; $display("FAIL clr_inflight_a: got %b/%h busy %b expected 1/7b busy 111", bus_a.rd_valid, bus_a.rd_data, {bus_a.busy, bus_b.busy, bus_c.busy});
        end
        step();
        checks++;
        if ({bus_b.rd_valid, bus_b.rd_data} !== {1'b1, 32'd123}) begin
            errors++; $display("FAIL clr_inflight_b: got %h expected 1_0000007b", {bus_b.rd_valid, bus_b.rd_data});
        end
        count_busy(1, na, nb, nc, seen);
        checks++;
        if (na !== 32 || nb !== 32 || nc !== 24) begin
            errors++; $display("FAIL clr_len: got %0d/%0d/%0d expected 32/32/24", na, nb, nc);
        end
        for (int i = 0; i < 4; i++) begin
            read_capture(5'(i), ra, rb, rc, lb);
            checks++;
            if ({ra, rb, rc} !== {1'b1, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0}) begin
                errors++; $display("FAIL clr_zero_%0d: got %h %h %h expected 1_00000000 x3", i, ra, rb, rc);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int na, nb, nc;
        logic seen, flushed;
        rd_en = 1'b1; rd_addr = 5'd1;
        step();
        rd_en = 1'b0;
        reset_n = 1'b0;
        #1;
        flushed = ~(bus_a.rd_valid | bus_b.rd_valid | bus_c.rd_valid);
        step();
        flushed = flushed & ~bus_b.rd_valid;
        checks++;
        if ({flushed, bus_a.busy, bus_b.busy, bus_c.busy} !== 4'b1111) begin
            errors++; $display("FAIL rst_mid_read: got flushed %b busy %b expected 1 111", flushed, {bus_a.busy, bus_b.busy, bus_c.busy});
        end
        reset_n = 1'b1;
        count_busy(0, na, nb, nc, seen);
        checks++;
        if (na !== 32 || nb !== 32 || nc !== 24 || seen !== 1'b0) begin
            errors++; $display("FAIL rst_read_refill: got %0d/%0d/%0d valid %b expected 32/32/24 valid 0", na, nb, nc, seen);
        end
    endtask

    task automatic test_reset_mid_clear();
        int na, nb, nc;
        logic seen;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_a.busy, bus_b.busy, bus_c.busy, bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid} !== 6'b111000) begin
            errors++; $display("FAIL rst_mid_clear: got %b expected 111000", {bus_a.busy, bus_b.busy, bus_c.busy, bus_a.rd_valid, bus_b.rd_valid, bus_c.rd_valid});
        end
        step(); step();
        reset_n = 1'b1;
        count_busy(0, na, nb, nc, seen);
        checks++;
        if (na !== 32 || nb !== 32 || nc !== 24 || seen !== 1'b0) begin
            errors++; $display("FAIL rst_clear_restart: got %0d/%0d/%0d valid %b expected 32/32/24 valid 0", na, nb, nc, seen);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_byte_enable();
        test_rdw();
        test_oob();
        test_back_to_back();
        test_clear_inflight();
        test_reset_mid_read();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
# ram_sdp_be

Parametrised simple-dual-port RAM with byte-enable writes, configurable read latency, selectable read-during-write behaviour and a hardware zero-fill engine. It replaces the single-port 32×32 data RAM in the processor's data-memory path. The new block allows one write and one independent read per cycle, and guarantees known (all-zero) contents after reset or on request.

## Interface
- `DATA_W`, 32: data width in bits; must be a multiple of 8.
- `ADDR_W`, 5: address width in bits.
- `DEPTH`, 32: number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 and 2.
- `RDW_NEW`, 0: read-during-write to the same address; 0 returns old data, 1 returns newly written data.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clear_req`, in, 1: one-cycle request to zero-fill the whole array.
- `busy`, out, 1: high while a zero-fill is in progress.
- `wr_en`, in, 1: write strobe.
- `wr_addr`, in, ADDR_W: write address.
- `wr_data`, in, DATA_W: write data.
- `wr_be`, in, DATA_W/8: byte enables; bit i covers `wr_data[8i+7:8i]`.
- `rd_en`, in, 1: read strobe.
- `rd_addr`, in, ADDR_W: read address.
- `rd_data`, out, DATA_W: read data.
- `rd_valid`, out, 1: qualifies `rd_data`.
- `oob_err`, out, 1: one-cycle pulse on any accepted access with address ≥ DEPTH.

## Operation
- The FSM has two states: CLEAR and READY.
- **Reset:** asserting `reset_n` low forces CLEAR with the clear counter at 0.
  - Outputs during reset: `busy`=1, `rd_data`=0, `rd_valid`=0, `oob_err`=0.
  - Array contents are not reset directly; the zero-fill cleans them.
- **CLEAR state:**
  - Writes zero to address `cnt` on each rising edge, then increments `cnt`.
  - Leaves CLEAR on the edge that writes address DEPTH-1 and enters READY.
  - Ignores `wr_en`, `rd_en` and `clear_req`; ignored reads produce no `rd_valid`.
- **READY state:**
  - `clear_req`=1 moves the FSM to CLEAR with `cnt`=0.
  - In that same cycle, a write or read is still performed; `clear_req` takes effect from the next edge.
- **Write:**
  - `wr_en` with `wr_addr` < DEPTH updates only the enabled bytes.
  - `wr_be`=0 is a legal no-op.
- **Read:**
  - `rd_en` captures `rd_addr`.
  - Data appears with `rd_valid`=1 exactly RD_LAT cycles later.
  - Back-to-back reads are fully pipelined, one per cycle.
- **Read-during-write, same address, same cycle:**
  - RDW_NEW=0 returns the pre-write word.
  - RDW_NEW=1 returns the byte-wise merge: enabled bytes from `wr_data`, the rest from the stored word.
- **Out of range (address ≥ DEPTH):**
  - A write is dropped.
  - A read still yields `rd_valid` with `rd_data`=0.
  - `oob_err` pulses for one cycle, aligned with the accepting edge plus 1.
  - A simultaneous out-of-range read and write produce a single pulse.
- **Address width:** addresses are compared at full ADDR_W width; there is no wrap-around or aliasing.
- **`rd_data` hold:** `rd_data` keeps its last value when `rd_valid`=0.

## Timing
- The zero-fill lasts exactly DEPTH rising edges after `reset_n` is released or after the `clear_req` edge.
  - `busy` falls after the final edge.
  - The first access is accepted in the cycle where `busy`=0.
- Read latency:
  - RD_LAT=1: `rd_data` is a register fed by the array.
  - RD_LAT=2: one extra output register stage.
  - `rd_valid` is shifted alongside in both cases.
- Reset mid-read: the pipeline is flushed and no `rd_valid` appears.
- Reset mid-clear: the fill restarts from address 0.
- A `clear_req` pulse with reads in flight: the in-flight reads still complete with their original data.

## Structure
- Package `ram_pkg` holds:
  - the state enum `ram_state_t` (ST_CLEAR, ST_READY);
  - the constants `RDW_OLD`=0 and `RDW_NEW_DATA`=1;
  - the function `be_merge(old, new, be)`, shared by the write path and the forwarding path.
- One sub-module, `ram_rd_pipe`: a parametrised RD_LAT-deep data/valid delay line with asynchronous clear.

## Test plan
- Release reset with DEPTH=32 → `busy` is high for 32 edges; then reading addr 5 → `rd_data`=0 and `rd_valid` after RD_LAT cycles.
- Write 369 to addr 0 with `wr_be`=4'hF, then read addr 0 → `rd_data`=369 after exactly RD_LAT cycles (check both RD_LAT=1 and RD_LAT=2).
- Write 32'hAABBCCDD to addr 1, then write 32'h11223344 with `wr_be`=4'b0101 → reading addr 1 returns 32'hAA22CC44.
- Addr 2 holds 123; in the same cycle write 999 and read addr 2:
  - RDW_NEW=0 → 123, and a later read → 999;
  - RDW_NEW=1 → 999.
- With DEPTH=24:
  - write 7 to addr 30 → one `oob_err` pulse, and no change at addr 30 mod 24 (addr 6);
  - read addr 30 → `rd_valid`=1, `rd_data`=0, `oob_err` pulse.
- Fill addrs 0–3 with 123, then:
  - `clear_req` → `busy` is high for DEPTH edges and all reads return 0;
  - assert `reset_n` at cnt=10 during a second clear → the fill restarts, `busy` stays high DEPTH edges after release, and no `rd_valid` appears.
